// File: rtl/memory_pkg.sv
// Shared types and constants for the memory (pairs) board turn logic.
// Latency: none, pure declarations; no backpressure.
package memory_pkg;

  localparam int N_CELLS_DEF = 16;
  localparam int LABEL_W_DEF = 4;

  typedef enum logic [2:0] {
    WAIT1,
    WAIT2,
    SHOW,
    CMP,
    DONE
  } turn_state_t;

  localparam logic [1:0] W_P0  = 2'b00;
  localparam logic [1:0] W_P1  = 2'b01;
  localparam logic [1:0] W_TIE = 2'b10;

  function automatic logic [1:0] decide_winner(input int unsigned s0, input int unsigned s1);
    if (s0 > s1)      return W_P0;
    else if (s1 > s0) return W_P1;
    else              return W_TIE;
  endfunction

endpackage

// File: rtl/turn_timer.sv
// Cycle counter with clear/enable; flags expiry when the count equals limit.
// Latency: expired follows the registered count combinationally; no backpressure.
module turn_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + W'(1);
  end

  assign expired = (count == limit);

endmodule

// File: rtl/memory_turn_ctrl.sv
// Turn sequencer for the memory board: two picks, show delay, compare, scoring, timeout.
// Latency: every output is registered, pulses appear the cycle after the pick; no backpressure, dropped picks are lost.
module memory_turn_ctrl
  import memory_pkg::*;
#(
  parameter int N_CELLS     = N_CELLS_DEF,
  parameter int LABEL_W     = LABEL_W_DEF,
  parameter int IDX_W       = $clog2(N_CELLS),
  parameter int SCORE_W     = $clog2(N_CELLS/2+1),
  parameter int SHOW_CYC    = 4,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                       clk_Temp,
  input  logic                       rst,
  input  logic                       sel_valid,
  input  logic [IDX_W-1:0]           sel_idx,
  input  logic [N_CELLS*LABEL_W-1:0] labels,
  output logic [N_CELLS-1:0]         select_vec,
  output logic [N_CELLS-1:0]         hide_vec,
  output logic [N_CELLS-1:0]         par_vec,
  output logic                       player,
  output logic [SCORE_W-1:0]         score0,
  output logic [SCORE_W-1:0]         score1,
  output logic                       timeout,
  output logic                       busy,
  output logic                       game_over,
  output logic [1:0]                 winner
);

  localparam int TMR_MAX = (TIMEOUT_CYC > SHOW_CYC) ? TIMEOUT_CYC : SHOW_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  // The pick timer fires on the idle cycle that would take it to TIMEOUT_CYC-1.
  localparam logic [TMR_W-1:0] PICK_LIM = TMR_W'(TIMEOUT_CYC - 2);
  localparam logic [TMR_W-1:0] SHOW_LIM = TMR_W'(SHOW_CYC - 1);
  localparam logic [N_CELLS-1:0] ONE = {{(N_CELLS-1){1'b0}}, 1'b1};

  turn_state_t         state;
  logic [IDX_W-1:0]    idx_a;
  logic [IDX_W-1:0]    idx_b;
  logic                legal;
  logic                tmr_clr;
  logic                tmr_en;
  logic                tmr_exp;
  logic [TMR_W-1:0]    tmr_lim;
  logic [LABEL_W-1:0]  label_a;
  logic [LABEL_W-1:0]  label_b;
  logic [N_CELLS-1:0]  pair_mask;
  logic [N_CELLS-1:0]  par_next;
  logic [SCORE_W-1:0]  score0_inc;
  logic [SCORE_W-1:0]  score1_inc;
  logic [SCORE_W-1:0]  final_s0;
  logic [SCORE_W-1:0]  final_s1;

  assign legal = sel_valid && (int'(sel_idx) < N_CELLS) && !par_vec[sel_idx]
                 && !((state == WAIT2) && (sel_idx == idx_a));

  assign label_a    = labels[idx_a*LABEL_W +: LABEL_W];
  assign label_b    = labels[idx_b*LABEL_W +: LABEL_W];
  assign pair_mask  = (ONE << idx_a) | (ONE << idx_b);
  assign par_next   = par_vec | pair_mask;
  assign score0_inc = score0 + SCORE_W'(1);
  assign score1_inc = score1 + SCORE_W'(1);
  assign final_s0   = player ? score0 : score0_inc;
  assign final_s1   = player ? score1_inc : score1;

  // One timer serves both the per-pick timeout and the SHOW hold.
  always_comb begin
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    tmr_lim = (state == SHOW) ? SHOW_LIM : PICK_LIM;
    case (state)
      WAIT1, WAIT2: begin
        if (legal || tmr_exp) tmr_clr = 1'b1;
        else                  tmr_en  = 1'b1;
      end
      SHOW: begin
        if (tmr_exp) tmr_clr = 1'b1;
        else         tmr_en  = 1'b1;
      end
      default: tmr_clr = 1'b1;
    endcase
  end

  turn_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk     (clk_Temp),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .limit   (tmr_lim),
    .expired (tmr_exp)
  );

  always_ff @(posedge clk_Temp or posedge rst) begin
    if (rst) begin
      state      <= WAIT1;
      idx_a      <= '0;
      idx_b      <= '0;
      select_vec <= '0;
      hide_vec   <= '0;
      par_vec    <= '0;
      player     <= 1'b0;
      score0     <= '0;
      score1     <= '0;
      timeout    <= 1'b0;
      busy       <= 1'b0;
      game_over  <= 1'b0;
      winner     <= W_P0;
    end else begin
      select_vec <= '0;
      hide_vec   <= '0;
      timeout    <= 1'b0;
      case (state)
        WAIT1: begin
          if (legal) begin
            idx_a      <= sel_idx;
            select_vec <= ONE << sel_idx;
            state      <= WAIT2;
          end else if (tmr_exp) begin
            timeout <= 1'b1;
            player  <= ~player;
          end
        end
        WAIT2: begin
          if (legal) begin
            idx_b      <= sel_idx;
            select_vec <= ONE << sel_idx;
            busy       <= 1'b1;
            state      <= SHOW;
          end else if (tmr_exp) begin
            timeout  <= 1'b1;
            hide_vec <= ONE << idx_a;
            player   <= ~player;
            state    <= WAIT1;
          end
        end
        SHOW: begin
          if (tmr_exp) state <= CMP;
        end
        CMP: begin
          busy <= 1'b0;
          if (label_a == label_b) begin
            par_vec <= par_next;
            if (player) score1 <= score1_inc;
            else        score0 <= score0_inc;
            if (&par_next) begin
              game_over <= 1'b1;
              winner    <= decide_winner(32'(final_s0), 32'(final_s1));
              state     <= DONE;
            end else begin
              state <= WAIT1;
            end
          end else begin
            hide_vec <= pair_mask;
            player   <= ~player;
            state    <= WAIT1;
          end
        end
        DONE: ;
        default: state <= WAIT1;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_turn_ctrl.sv
// Directed bench for memory_turn_ctrl: match, miss, illegal picks, timeouts, full games, async reset.
// Latency: checks sample 1 time unit after each rising edge; no backpressure.
module tb_memory_turn_ctrl;

  localparam int N_CELLS = 16;
  localparam int LABEL_W = 4;
  localparam int IDX_W   = 4;
  localparam int SCORE_W = 4;

  logic                       clk_Temp = 1'b0;
  logic                       rst = 1'b1;
  logic                       sel_valid = 1'b0;
  logic [IDX_W-1:0]           sel_idx = '0;
  logic [N_CELLS*LABEL_W-1:0] labels = '0;
  logic [N_CELLS-1:0]         select_vec;
  logic [N_CELLS-1:0]         hide_vec;
  logic [N_CELLS-1:0]         par_vec;
  logic                       player;
  logic [SCORE_W-1:0]         score0;
  logic [SCORE_W-1:0]         score1;
  logic                       timeout;
  logic                       busy;
  logic                       game_over;
  logic [1:0]                 winner;

  int n_tests = 0;
  int n_fail  = 0;

  memory_turn_ctrl dut (
    .clk_Temp   (clk_Temp),
    .rst        (rst),
    .sel_valid  (sel_valid),
    .sel_idx    (sel_idx),
    .labels     (labels),
    .select_vec (select_vec),
    .hide_vec   (hide_vec),
    .par_vec    (par_vec),
    .player     (player),
    .score0     (score0),
    .score1     (score1),
    .timeout    (timeout),
    .busy       (busy),
    .game_over  (game_over),
    .winner     (winner)
  );

  always #5 clk_Temp = ~clk_Temp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_Temp);
    #1;
  endtask

  task automatic do_pick(input int idx);
    sel_valid = 1'b1;
    sel_idx   = IDX_W'(idx);
    tick();
    sel_valid = 1'b0;
  endtask

  task automatic wait_not_busy();
    int n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    chk("busy_release", 32'(busy), 0);
  endtask

  task automatic play_turn(input int a, input int b);
    do_pick(a);
    do_pick(b);
    wait_not_busy();
  endtask

  task automatic count_to_timeout(input string tag, output int n);
    n = 0;
    while (!timeout && n < 40) begin
      tick();
      n++;
    end
    chk(tag, 32'(n), 14);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    #2;
    rst = 1'b0;
  endtask

  always @(negedge clk_Temp) begin
    chk("sel_hide_excl", 32'(|select_vec && |hide_vec), 0);
    chk("sel_onehot", 32'($countones(select_vec) <= 1), 1);
    chk("score_sum", 32'((int'(score0) + int'(score1)) <= N_CELLS/2), 1);
  end

  initial begin
    int lab[N_CELLS] = '{8, 3, 7, 1, 3, 8, 7, 1, 10, 10, 11, 11, 12, 12, 13, 13};
    int n;
    for (int i = 0; i < N_CELLS; i++) labels[i*LABEL_W +: LABEL_W] = LABEL_W'(lab[i]);

    // Reset values
    tick();
    chk("rst_select", 32'(select_vec), 0);
    chk("rst_hide", 32'(hide_vec), 0);
    chk("rst_par", 32'(par_vec), 0);
    chk("rst_player", 32'(player), 0);
    chk("rst_scores", {score1, score0}, 0);
    chk("rst_flags", {timeout, busy, game_over}, 0);
    chk("rst_winner", 32'(winner), 0);
    #2;
    rst = 1'b0;

    // Match 0 and 5
    do_pick(0);
    chk("match_sel_a", 32'(select_vec), 32'h0001);
    do_pick(5);
    chk("match_sel_b", 32'(select_vec), 32'h0020);
    n = busy ? 1 : 0;
    while (busy && n < 20) begin
      tick();
      if (busy) n++;
    end
    chk("match_busy_cycles", 32'(n), 5);
    chk("match_par", 32'(par_vec), 32'h0021);
    chk("match_score0", 32'(score0), 1);
    chk("match_player", 32'(player), 0);

    // Illegal picks and a miss on 1/2
    do_pick(0);
    chk("illegal_matched", 32'(select_vec), 0);
    do_pick(1);
    chk("miss_sel_a", 32'(select_vec), 32'h0002);
    do_pick(1);
    chk("illegal_same", 32'(select_vec), 0);
    do_pick(2);
    chk("miss_sel_b", 32'(select_vec), 32'h0004);
    chk("miss_busy", 32'(busy), 1);
    do_pick(3);
    chk("illegal_show", 32'(select_vec), 0);
    chk("show_busy", 32'(busy), 1);
    wait_not_busy();
    chk("miss_hide", 32'(hide_vec), 32'h0006);
    chk("miss_player", 32'(player), 1);
    chk("miss_score0", 32'(score0), 1);
    chk("miss_par", 32'(par_vec), 32'h0021);

    // Timeout in WAIT1, then in WAIT2
    count_to_timeout("to_w1_cycles", n);
    chk("to_w1_player", 32'(player), 0);
    chk("to_w1_hide", 32'(hide_vec), 0);
    do_pick(3);
    chk("to_w2_sel", 32'(select_vec), 32'h0008);
    count_to_timeout("to_w2_cycles", n);
    chk("to_w2_hide", 32'(hide_vec), 32'h0008);
    chk("to_w2_player", 32'(player), 1);
    do_pick(3);
    chk("to_w2_back_w1", 32'(select_vec), 32'h0008);
    do_pick(7);
    chk("pre_rst_busy", 32'(busy), 1);

    // Asynchronous reset in the middle of SHOW
    #2;
    rst = 1'b1;
    #1;
    chk("arst_select", 32'(select_vec), 0);
    chk("arst_par", 32'(par_vec), 0);
    chk("arst_player", 32'(player), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_scores", {score1, score0}, 0);
    #2;
    rst = 1'b0;
    do_pick(0);
    chk("arst_restart", 32'(select_vec), 32'h0001);

    // Full game, p0 finds 5 and p1 finds 3
    do_reset();
    play_turn(0, 5);
    play_turn(1, 4);
    play_turn(2, 6);
    play_turn(3, 7);
    play_turn(8, 9);
    chk("g53_player_p0", 32'(player), 0);
    play_turn(10, 12);
    chk("g53_hide", 32'(hide_vec), 32'h1400);
    chk("g53_player_p1", 32'(player), 1);
    play_turn(10, 11);
    play_turn(12, 13);
    chk("g53_not_over", 32'(game_over), 0);
    play_turn(14, 15);
    chk("g53_over", 32'(game_over), 1);
    chk("g53_winner", 32'(winner), 0);
    chk("g53_score0", 32'(score0), 5);
    chk("g53_score1", 32'(score1), 3);
    chk("g53_par", 32'(par_vec), 32'hFFFF);
    do_pick(4);
    tick();
    chk("g53_done_hold", {select_vec, 3'(winner), game_over}, 32'h1);

    // Full game, 4-4 tie
    do_reset();
    chk("tie_rst_over", 32'(game_over), 0);
    play_turn(0, 5);
    play_turn(1, 4);
    play_turn(2, 6);
    play_turn(3, 7);
    play_turn(8, 10);
    play_turn(8, 9);
    play_turn(10, 11);
    play_turn(12, 13);
    play_turn(14, 15);
    chk("tie_over", 32'(game_over), 1);
    chk("tie_winner", 32'(winner), 2);
    chk("tie_scores", {score1, score0}, 32'h44);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_turn_ctrl.md
Name: memory_turn_ctrl

Overview:
- Turn sequencer for the memory (pairs) board built from N_CELLS casilla cells.
- Accepts one cell pick per request, then flips two cells per turn.
- Shows both flipped cells for a fixed time, then compares their labels. A match drives the cells' par; a miss hides the two cells.
- Tracks the player, per-player scores, the per-pick timeout and the end of the game. Sits between the input decoder and the casilla array.

Parameters:
- N_CELLS, 16, number of board cells; must be even.
- LABEL_W, 4, label width per cell.
- IDX_W, $clog2(N_CELLS), width of a cell index.
- SCORE_W, $clog2(N_CELLS/2+1), score counter width.
- SHOW_CYC, 4, cycles both cards stay visible before compare; must be ≥1.
- TIMEOUT_CYC, 15, idle cycles allowed per pick before the turn is forfeited; must be ≥2.

Ports:
- clk_Temp  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- sel_valid  in  1  pick request, one-cycle strobe.
- sel_idx  in  IDX_W  index of the picked cell.
- labels  in  N_CELLS*LABEL_W  flattened cell labels; cell i is at [i*LABEL_W +: LABEL_W].
- select_vec  out  N_CELLS  one-cycle one-hot flip pulse to a casilla.
- hide_vec  out  N_CELLS  one-cycle pulse that turns cells face-down.
- par_vec  out  N_CELLS  sticky matched flags, fed to each casilla's par input.
- player  out  1  current player (0/1), fed to the casilla player input.
- score0, score1  out  SCORE_W  pairs found by each player.
- timeout  out  1  one-cycle pulse when a pick times out.
- busy  out  1  high in SHOW and CMP states.
- game_over  out  1  sticky, high once all cells are matched.
- winner  out  2  valid when game_over: 00 = p0, 01 = p1, 10 = tie.

Behaviour:
- Reset (async, rst=1): state=WAIT1, player=0, scores=0, par_vec=0, select_vec=0, hide_vec=0, timeout=0, game_over=0, winner=00, timer=0, idx registers=0.
- All outputs are registered. A select_vec pulse appears in the cycle after the accepted sel_valid.
- A pick is legal when sel_idx < N_CELLS, par_vec[sel_idx]=0, and (in WAIT2) sel_idx != idx_a. Illegal picks are ignored, produce no pulse, and do not reset the timer.
- WAIT1:
  - Legal pick: idx_a ← sel_idx, pulse select_vec[idx_a], timer ← 0, go to WAIT2.
  - Otherwise timer++. When timer reaches TIMEOUT_CYC-1: pulse timeout, toggle player, timer ← 0, stay in WAIT1.
- WAIT2:
  - Legal pick: idx_b ← sel_idx, pulse select_vec[idx_b], show counter ← 0, go to SHOW.
  - On timeout: pulse timeout, pulse hide_vec[idx_a], toggle player, timer ← 0, go to WAIT1.
- Same-cycle legal pick and timer expiry: the pick wins and no timeout pulse is issued.
- SHOW: count SHOW_CYC cycles, ignoring sel_valid, then go to CMP.
- CMP (one cycle): compare the labels of idx_a and idx_b, sampled this cycle.
  - Equal: set par_vec[idx_a] and par_vec[idx_b]. The current player's score increments by 1 and the same player keeps the turn.
  - Different: pulse hide_vec on both cells and toggle player.
  - Next state is DONE if par_vec becomes all ones, else WAIT1 with timer ← 0.
- DONE: game_over=1; winner is computed from the scores. All sel_valid is ignored and every output holds until rst.
- Assertions (checked in the bench):
  - select_vec and hide_vec are never nonzero in the same cycle.
  - popcount(select_vec) ≤ 1.
  - Scores saturate by construction: the sum never exceeds N_CELLS/2.
- Reset asserted mid-turn (any state) returns to the reset values immediately. No hide pulse is issued; the cells are reset by the shared rst.

Decomposition:
- Package memory_pkg:
  - typedef turn_state_t {WAIT1, WAIT2, SHOW, CMP, DONE}.
  - winner encoding constants W_P0, W_P1, W_TIE.
  - default N_CELLS and LABEL_W.
- One sub-module, turn_timer: load/clear, enable, expiry flag at TIMEOUT_CYC-1. It is reused for the SHOW count with a separate limit input.

Test Plan:
- Match: labels with cells 0 and 5 both =4'h8; pick 0 then 5. Expect:
  - select_vec=0x0001 then 0x0020;
  - busy high for 5 cycles;
  - par_vec=0x0021, score0=1, player stays 0.
- Miss: cell 1 label 3, cell 2 label 7; pick 1 then 2. After SHOW expect hide_vec=0x0006 for one cycle, player=1, score0 unchanged.
- Illegal picks:
  - re-pick matched cell 0 in WAIT1 → no pulse;
  - pick idx_a again in WAIT2 → no pulse, state remains WAIT2;
  - sel_valid during SHOW → ignored.
- Timeout: no picks for 14 cycles in WAIT1 → timeout pulse, player toggles. Pick 3, then wait 14 cycles → timeout, hide_vec=0x0008, state WAIT1.
- Full game: 8 scripted pairs, with p0 finding 5 and p1 finding 3. Expect game_over=1, winner=00, score0=5, score1=3. A 4–4 split gives winner=10.
- Reset mid-SHOW: assert rst asynchronously between clock edges. All outputs return to reset values that same cycle, and play restarts in WAIT1 after rst drops.
